// File: rtl/video_stream_monitor.sv
// Frame-aware sink/checker for the ISP pixel stream: generates backpressure, tracks
// pixel position from the configured geometry, checks sideband flags and checksums frames.
module video_stream_monitor #(
  parameter int PIX_WID      = 24,
  parameter int STALL_PERIOD = 0,
  parameter int SUM_WID      = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [15:0]        img_width,
  input  logic [15:0]        img_height,
  input  logic [7:0]         frame_target,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_WID-1:0] s_data,
  input  logic               s_start,
  input  logic               s_line_last,
  input  logic               s_last,
  output logic               pix_fire,
  output logic [PIX_WID-1:0] pix_data,
  output logic               gen_last,
  output logic [15:0]        col,
  output logic [15:0]        row,
  output logic [7:0]         frame_cnt,
  output logic [SUM_WID-1:0] frame_sum,
  output logic               err_cfg,
  output logic               err_start,
  output logic               err_line,
  output logic               err_last,
  output logic               done
);

  localparam int SC_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              state;
  logic                enable_d;
  logic [15:0]         width_q;
  logic [15:0]         height_q;
  logic [SUM_WID-1:0]  run_sum;
  logic [SC_W-1:0]     stall_cnt;
  logic                stall_ok;
  logic                fire;
  logic                first_pix;
  logic                at_line_end;
  logic                at_frame_end;
  logic                target_hit;
  logic                vld_p1;
  logic [PIX_WID-1:0]  pix_data_p1;
  logic                gen_last_p1;

  // Checksum accumulates zero-extended pixels and wraps modulo 2^SUM_WID.
  function automatic logic [SUM_WID-1:0] sum_wrap(input logic [SUM_WID-1:0] acc,
                                                  input logic [PIX_WID-1:0] pix);
    return acc + SUM_WID'(pix);
  endfunction

  always_comb begin
    stall_ok = 1'b1;
    if (STALL_PERIOD > 0) stall_ok = (stall_cnt != SC_W'(STALL_PERIOD - 1));
  end

  assign s_ready      = (state == ST_RUN) && stall_ok;
  assign fire         = s_valid && s_ready;
  assign first_pix    = (col == 16'd0) && (row == 16'd0);
  assign at_line_end  = (col == width_q - 16'd1);
  assign at_frame_end = at_line_end && (row == height_q - 16'd1);
  assign target_hit   = (frame_target != 8'd0) && ((frame_cnt + 8'd1) == frame_target);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      enable_d    <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
      run_sum     <= '0;
      stall_cnt   <= '0;
      col         <= '0;
      row         <= '0;
      frame_cnt   <= '0;
      frame_sum   <= '0;
      err_cfg     <= 1'b0;
      err_start   <= 1'b0;
      err_line    <= 1'b0;
      err_last    <= 1'b0;
      vld_p1      <= 1'b0;
      pix_data_p1 <= '0;
      gen_last_p1 <= 1'b0;
    end else begin
      enable_d    <= enable;
      vld_p1      <= 1'b0;
      gen_last_p1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && !enable_d) begin
            if (img_width != 16'd0 && img_height != 16'd0) begin
              state     <= ST_RUN;
              width_q   <= img_width;
              height_q  <= img_height;
              stall_cnt <= '0;
            end else begin
              err_cfg <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (STALL_PERIOD > 0) begin
            if (stall_cnt == SC_W'(STALL_PERIOD - 1)) stall_cnt <= '0;
            else                                      stall_cnt <= stall_cnt + SC_W'(1);
          end
          if (fire) begin
            // ---- stage p1: accepted pixel registered toward the outputs ----
            vld_p1      <= 1'b1;
            pix_data_p1 <= s_data;
            gen_last_p1 <= at_frame_end;
            err_start   <= err_start | (s_start != first_pix);
            err_line    <= err_line  | (s_line_last != at_line_end);
            err_last    <= err_last  | (s_last != at_frame_end);
            // Position follows geometry only; flags never resync the counters.
            if (at_frame_end) begin
              col       <= '0;
              row       <= '0;
              frame_cnt <= frame_cnt + 8'd1;
              frame_sum <= sum_wrap(run_sum, s_data);
              run_sum   <= '0;
              if (target_hit) state <= ST_DONE;
            end else begin
              run_sum <= sum_wrap(run_sum, s_data);
              if (at_line_end) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign pix_fire = vld_p1;
  assign pix_data = pix_data_p1;
  assign gen_last = gen_last_p1;
  assign done     = (state == ST_DONE);

endmodule
